// File: rtl/wimax_fec_pkg.sv
// Shared WiMAX FEC constants: code-rate encodings, puncture tables and the
// default K=7 convolutional generator polynomials.
package wimax_fec_pkg;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'd0,
    RATE_2_3 = 2'd1,
    RATE_3_4 = 2'd2,
    RATE_5_6 = 2'd3
  } cc_rate_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_TAIL,
    ST_DRAIN
  } cc_state_e;

  localparam logic [6:0] CC_G0_DEF = 7'o171;
  localparam logic [6:0] CC_G1_DEF = 7'o133;

  // Indexed by rate; mask bit p keeps (1) or punctures (0) the branch at index p
  localparam logic [3:0][2:0] PUNC_PERIOD = {3'd5, 3'd3, 3'd2, 3'd1};
  localparam logic [3:0][4:0] X_MASK      = {5'b10101, 5'b00101, 5'b00001, 5'b00001};
  localparam logic [3:0][4:0] Y_MASK      = {5'b01011, 5'b00011, 5'b00011, 5'b00001};

  // Coded bits of one encoded input bit still waiting to leave (X before Y)
  typedef struct packed {
    logic x_vld;
    logic y_vld;
    logic x;
    logic y;
    logic last;
  } cc_pend_t;

endpackage

// File: rtl/cc_shift_encoder.sv
// Constraint-length-K shift register with X/Y parity taps; clear makes the
// current bit see an all-zero history (frame start).
module cc_shift_encoder
  import wimax_fec_pkg::*;
#(
  parameter int           K  = 7,
  parameter logic [K-1:0] G0 = K'(CC_G0_DEF),
  parameter logic [K-1:0] G1 = K'(CC_G1_DEF)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic b,
  output logic x,
  output logic y
);

  logic [K-2:0] sr;
  logic [K-2:0] sr_eff;
  logic [K-1:0] v;

  assign sr_eff = clear ? '0 : sr;
  assign v      = {b, sr_eff};
  assign x      = ^(v & G0);
  assign y      = ^(v & G1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   sr <= '0;
    else if (en) sr <= v[K-1:1];
  end

endmodule

// File: rtl/cc_encoder.sv
// Serial punctured convolutional encoder with optional zero tail; one coded
// bit per output handshake, one data bit accepted per drained encoded bit.
module cc_encoder
  import wimax_fec_pkg::*;
#(
  parameter int           K  = 7,
  parameter logic [K-1:0] G0 = K'(CC_G0_DEF),
  parameter logic [K-1:0] G1 = K'(CC_G1_DEF)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  input  logic [1:0] cc_rate,
  input  logic       tail_en,
  output logic       busy
);

  cc_state_e state, state_nxt;
  cc_rate_e  rate_q, rate_eff;
  logic      tail_q, tail_eff;
  logic [2:0] p_q, p_cur, p_nxt;
  logic [3:0] tcnt_q;
  cc_pend_t  pend_q;
  logic pend_any, in_hs, out_hs, frame_clr;
  logic tail_go, tail_done, enc_en, enc_bit, enc_last, x_par, y_par;

  assign pend_any  = pend_q.x_vld | pend_q.y_vld;
  assign out_valid = pend_any;
  assign out_bit   = pend_q.x_vld ? pend_q.x : pend_q.y;
  // Last only once the final encoded bit has a single coded bit left
  assign out_last  = pend_q.last & (pend_q.x_vld ^ pend_q.y_vld);
  assign in_ready  = !reset && (state == ST_IDLE || state == ST_DATA) && !pend_any;
  assign busy      = (state != ST_IDLE);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  assign frame_clr = (state == ST_IDLE);
  assign rate_eff  = frame_clr ? cc_rate_e'(cc_rate) : rate_q;
  assign tail_eff  = frame_clr ? tail_en : tail_q;
  assign tail_go   = (state == ST_TAIL) && !pend_any;
  assign tail_done = (tcnt_q == 4'(K-2));
  assign enc_en    = in_hs | tail_go;
  assign enc_bit   = tail_go ? 1'b0 : in_bit;
  assign p_cur     = frame_clr ? 3'd0 : p_q;
  assign p_nxt     = (p_cur == PUNC_PERIOD[rate_eff] - 3'd1) ? 3'd0 : p_cur + 3'd1;

  cc_shift_encoder #(.K(K), .G0(G0), .G1(G1)) u_enc (
    .clk   (clk),
    .reset (reset),
    .clear (frame_clr),
    .en    (enc_en),
    .b     (enc_bit),
    .x     (x_par),
    .y     (y_par)
  );

  always_comb begin
    state_nxt = state;
    enc_last  = 1'b0;
    case (state)
      ST_IDLE, ST_DATA: begin
        if (in_hs && in_last) begin
          state_nxt = tail_eff ? ST_TAIL : ST_DRAIN;
          enc_last  = !tail_eff;
        end else if (in_hs) begin
          state_nxt = ST_DATA;
        end
      end
      ST_TAIL: begin
        if (tail_go && tail_done) begin
          state_nxt = ST_DRAIN;
          enc_last  = 1'b1;
        end
      end
      ST_DRAIN: if (out_hs && out_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      rate_q <= RATE_1_2;
      tail_q <= 1'b0;
      p_q    <= '0;
      tcnt_q <= '0;
      pend_q <= '0;
    end else begin
      state <= state_nxt;
      if (in_hs && frame_clr) begin
        rate_q <= cc_rate_e'(cc_rate);
        tail_q <= tail_en;
      end
      // A new bit is only encoded once the previous one has fully drained
      if (enc_en) begin
        p_q    <= p_nxt;
        pend_q <= '{x_vld: X_MASK[rate_eff][p_cur], y_vld: Y_MASK[rate_eff][p_cur],
                    x: x_par, y: y_par, last: enc_last};
      end else if (out_hs) begin
        if (pend_q.x_vld) pend_q.x_vld <= 1'b0;
        else              pend_q.y_vld <= 1'b0;
      end
      if (state != ST_TAIL) tcnt_q <= '0;
      else if (tail_go)     tcnt_q <= tcnt_q + 4'd1;
    end
  end

endmodule

// File: tb/tb_cc_encoder.sv
// Directed vector bench for cc_encoder: hand-computed impulse/puncture
// vectors, reference-model frames under random back-pressure, reset, back-to-back.
module tb_cc_encoder;

  logic       clk = 1'b0, reset = 1'b1;
  logic       in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic       out_bit, out_valid, out_last, out_ready = 1'b0;
  logic [1:0] cc_rate = 2'd0;
  logic       tail_en = 1'b0, busy;

  int total = 0, bad = 0;
  bit got_q[$], exp_q[$];
  int viol;
  bit col_done, drv_done;
  int b2b_lows, b2b_cyc;
  bit b2b_hi, b2b_end;

  typedef struct {
    logic [1:0]  rate;
    bit          tail;
    int          n;
    logic [31:0] data;   // MSB-first: data[n-1] is the first bit
    int          nout;   // 0 -> expected stream from the reference model
    logic [31:0] exp;    // MSB-first: exp[nout-1] is the first coded bit
    int          stall;  // percent of cycles with out_ready low
    bit          tog;    // toggle cc_rate/tail_en mid-frame
  } vec_t;
  vec_t vecs[10];

  cc_encoder dut (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .cc_rate(cc_rate), .tail_en(tail_en), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic void build_model(input logic [1:0] rate, input bit tail,
                                      input int n, input logic [31:0] data);
    int per[4]    = '{1, 2, 3, 5};
    bit xm[4][5]  = '{'{1,0,0,0,0}, '{1,0,0,0,0}, '{1,0,1,0,0}, '{1,0,1,0,1}};
    bit ym[4][5]  = '{'{1,0,0,0,0}, '{1,1,0,0,0}, '{1,1,0,0,0}, '{1,1,0,1,0}};
    logic [5:0] sr = '0;
    logic [6:0] v;
    int p = 0;
    bit b;
    exp_q.delete();
    for (int j = 0; j < n + (tail ? 6 : 0); j++) begin
      b = (j < n) ? data[n-1-j] : 1'b0;
      v = {b, sr};
      if (xm[rate][p]) exp_q.push_back(^(v & 7'o171));
      if (ym[rate][p]) exp_q.push_back(^(v & 7'o133));
      sr = v[6:1];
      p  = (p + 1) % per[rate];
    end
  endfunction

  task automatic drive(input int n, input logic [31:0] data, input bit tog);
    int i = 0, cyc = 0;
    while (i < n && cyc < 800) begin
      @(negedge clk); cyc++;
      if (tog && i > 0) begin cc_rate = cc_rate + 2'd1; tail_en = ~tail_en; end
      in_valid = 1'b1; in_bit = data[n-1-i]; in_last = (i == n - 1);
      if (in_ready) i++;
    end
    drv_done = (i == n);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic collect(input int stall);
    int cyc = 0;
    bit hold = 0;
    logic hb = 1'b0, hl = 1'b0;
    col_done = 0; viol = 0;
    while (!col_done && cyc < 800) begin
      @(negedge clk); cyc++;
      if (hold && (out_valid !== 1'b1 || out_bit !== hb || out_last !== hl)) viol++;
      out_ready = ($urandom_range(99) >= stall);
      hold = out_valid && !out_ready; hb = out_bit; hl = out_last;
      if (out_valid && out_ready) begin
        got_q.push_back(out_bit);
        if (out_last) col_done = 1;
      end
    end
  endtask

  task automatic run_frame(input vec_t vv, input string tag);
    logic [63:0] gv, ev;
    cc_rate = vv.rate; tail_en = vv.tail; got_q.delete();
    if (vv.nout == 0) build_model(vv.rate, vv.tail, vv.n, vv.data);
    else begin
      exp_q.delete();
      for (int i = 0; i < vv.nout; i++) exp_q.push_back(vv.exp[vv.nout-1-i]);
    end
    fork
      drive(vv.n, vv.data, vv.tog);
      collect(vv.stall);
    join
    gv = '0; ev = '0;
    for (int i = 0; i < got_q.size() && i < 64; i++) gv[i] = got_q[i];
    for (int i = 0; i < exp_q.size() && i < 64; i++) ev[i] = exp_q[i];
    chk({tag, " in_done"}, 64'(drv_done), 64'd1);
    chk({tag, " out_last_seen"}, 64'(col_done), 64'd1);
    chk({tag, " len"}, 64'(got_q.size()), 64'(exp_q.size()));
    chk({tag, " bits"}, gv, ev);
    chk({tag, " stable"}, 64'(viol), 64'd0);
  endtask

  initial begin
    vecs[0] = '{2'd0, 1'b1, 1,  32'h1,   14, 32'b11101111000111, 0,  1'b0};
    vecs[1] = '{2'd2, 1'b0, 6,  32'h20,  8,  32'b11011100,       0,  1'b0};
    vecs[2] = '{2'd3, 1'b0, 10, 32'h200, 12, 32'b110110011000,   0,  1'b0};
    vecs[3] = '{2'd1, 1'b0, 4,  32'h8,   6,  32'b110111,         0,  1'b0};
    vecs[4] = '{2'd2, 1'b0, 6,  32'h20,  8,  32'b11011100,       50, 1'b1};
    vecs[5] = '{2'd0, 1'b1, 12, 32'hB4D, 0,  32'h0,              50, 1'b0};
    vecs[6] = '{2'd1, 1'b1, 12, 32'h5A3, 0,  32'h0,              50, 1'b0};
    vecs[7] = '{2'd2, 1'b1, 12, 32'hE71, 0,  32'h0,              50, 1'b0};
    vecs[8] = '{2'd3, 1'b0, 12, 32'h29C, 0,  32'h0,              50, 1'b1};
    vecs[9] = '{2'd0, 1'b0, 3,  32'h5,   6,  32'b111000,         50, 1'b0};

    #2;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready",  64'(in_ready),  64'd0);
    chk("reset busy",      64'(busy),      64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0; #1;
    chk("release in_ready", 64'(in_ready), 64'd1);

    for (int k = 0; k < 10; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

    // Reset in the middle of a stalled rate-1/2 frame
    @(negedge clk);
    cc_rate = 2'd0; tail_en = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst pre out_valid", 64'(out_valid), 64'd1);
    chk("midrst pre busy",      64'(busy),      64'd1);
    #2 reset = 1'b1; #1;
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst out_bit",   64'(out_bit),   64'd0);
    chk("midrst out_last",  64'(out_last),  64'd0);
    chk("midrst in_ready",  64'(in_ready),  64'd0);
    chk("midrst busy",      64'(busy),      64'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("midrst release in_ready", 64'(in_ready), 64'd1);
    run_frame(vecs[0], "post_rst");

    // Back-to-back frames: busy must drop for exactly one cycle
    b2b_lows = 0; b2b_cyc = 0; b2b_hi = 0; b2b_end = 0;
    fork
      begin
        run_frame(vecs[3], "b2b_a");
        run_frame(vecs[9], "b2b_b");
      end
      begin
        while (!b2b_end && b2b_cyc < 1000) begin
          @(negedge clk); b2b_cyc++;
          if (!b2b_hi) b2b_hi = busy;
          else if (!busy) b2b_lows++;
          else if (b2b_lows > 0) b2b_end = 1;
        end
      end
    join
    chk("b2b second frame seen", 64'(b2b_end), 64'd1);
    chk("b2b busy low cycles", 64'(b2b_lows), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
